// File: rtl/roulette_spinner.sv
`default_nettype none
// ============================================================================
// Module   : roulette_spinner
// Brief    : Decelerating wheel-spin number generator feeding the even/odd game.
// Revision : 1.0 - initial release
// ============================================================================
module roulette_spinner #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          NUM_MAX   = 20,
  parameter int          STEP_INIT = 2,
  parameter int          STEP_INC  = 2,
  parameter int          STEP_MAX  = 10
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       spin,
  output logic       busy,
  output logic [4:0] spin_num,
  output logic [4:0] randnum,
  output logic       result_valid
);

  localparam logic [15:0] c_seed      = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] c_taps      = 16'hB400;
  localparam logic [15:0] c_step_init = 16'(STEP_INIT);
  localparam logic [15:0] c_step_inc  = 16'(STEP_INC);
  localparam logic [15:0] c_step_max  = 16'(STEP_MAX);
  localparam logic [4:0]  c_num_max   = 5'(NUM_MAX);
  localparam logic [4:0]  c_wrap_sub  = 5'(NUM_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SPIN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic        r_spin_d;
  logic [15:0] r_interval;
  logic [15:0] r_cnt;

  logic        w_start;
  logic [4:0]  w_raw;
  logic [4:0]  w_mapped;
  logic [15:0] w_next_interval;
  logic        w_last_step;

  assign w_start         = spin & ~r_spin_d;
  assign w_raw           = r_lfsr[4:0];
  // NUM_MAX >= 15 guarantees one subtraction brings any 5-bit value in range
  assign w_mapped        = (w_raw > c_num_max) ? (w_raw - c_wrap_sub) : w_raw;
  assign w_next_interval = r_interval + c_step_inc;
  assign w_last_step     = (w_next_interval > c_step_max);

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lfsr       <= c_seed;
      r_spin_d     <= 1'b0;
      r_interval   <= 16'd0;
      r_cnt        <= 16'd0;
      busy         <= 1'b0;
      spin_num     <= 5'd0;
      randnum      <= 5'd0;
      result_valid <= 1'b0;
    end else begin
      // Free-running so the moment the player presses adds entropy
      r_lfsr   <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_taps : 16'h0000);
      r_spin_d <= spin;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_SPIN;
            busy       <= 1'b1;
            r_interval <= c_step_init;
            r_cnt      <= 16'd0;
          end
        end

        S_SPIN: begin
          if (r_cnt == r_interval - 16'd1) begin
            spin_num   <= w_mapped;
            r_cnt      <= 16'd0;
            r_interval <= w_next_interval;
            if (w_last_step) begin
              randnum      <= w_mapped;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              r_state      <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DONE: begin
          result_valid <= 1'b0;
          if (w_start) begin
            r_state    <= S_SPIN;
            busy       <= 1'b1;
            r_interval <= c_step_init;
            r_cnt      <= 16'd0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_roulette_spinner.sv
`default_nettype none
// Testbench for roulette_spinner: directed spins checked against an
// independent LFSR/mapping model running alongside the DUT.
module tb_roulette_spinner;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       spin  = 1'b0;
  logic       busy;
  logic [4:0] spin_num;
  logic [4:0] randnum;
  logic       result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  int          exp_num  = 0;
  int          exp_rand = 0;

  roulette_spinner dut (
    .Clock        (Clock),
    .reset        (reset),
    .spin         (spin),
    .busy         (busy),
    .spin_num     (spin_num),
    .randnum      (randnum),
    .result_valid (result_valid)
  );

  always #5 Clock = ~Clock;

  // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting form
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[15] = ~n[15];
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  function automatic int wheel_map(input logic [15:0] s);
    int v;
    v = int'(s[4:0]);
    if (v >= 21) return v - 21;
    return v;
  endfunction

  always @(posedge Clock or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic bit is_step_edge(input int k);
    return (k == 2) || (k == 6) || (k == 12) || (k == 20) || (k == 30);
  endfunction

  // One complete spin from a rising edge on spin; optional extra edge at glitch_at
  task automatic run_spin(input int glitch_at);
    logic [15:0] pre;
    @(negedge Clock);
    spin = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL spin_start: busy=%b result_valid=%b, required busy=1 result_valid=0", busy, result_valid);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clock);
      if (glitch_at != 0 && k == glitch_at - 1) spin = 1'b0;
      if (glitch_at != 0 && k == glitch_at)     spin = 1'b1;
      pre = m_lfsr;
      @(posedge Clock); #1;
      if (is_step_edge(k)) exp_num = wheel_map(pre);
      n_checks++;
      if (int'(spin_num) !== exp_num) begin
        n_fail++;
        $display("FAIL spin_num cycle %0d: got %0d, required %0d", k, spin_num, exp_num);
      end
      if (k == 30) begin
        exp_rand = exp_num;
        n_checks++;
        if (busy !== 1'b0 || result_valid !== 1'b1 || int'(randnum) !== exp_rand) begin
          n_fail++;
          $display("FAIL spin_end: busy=%b result_valid=%b randnum=%0d, required busy=0 result_valid=1 randnum=%0d",
                   busy, result_valid, randnum, exp_rand);
        end
        n_checks++;
        if (randnum > 5'd20) begin
          n_fail++;
          $display("FAIL randnum_range: got %0d, required <= 20", randnum);
        end
      end else begin
        n_checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0 || int'(randnum) !== exp_rand) begin
          n_fail++;
          $display("FAIL spin_mid cycle %0d: busy=%b result_valid=%b randnum=%0d, required busy=1 result_valid=0 randnum=%0d",
                   k, busy, result_valid, randnum, exp_rand);
        end
      end
    end
    @(posedge Clock); #1;
    n_checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || int'(randnum) !== exp_rand || int'(spin_num) !== exp_num) begin
      n_fail++;
      $display("FAIL spin_after: busy=%b result_valid=%b randnum=%0d spin_num=%0d, required 0 0 %0d %0d",
               busy, result_valid, randnum, spin_num, exp_rand, exp_num);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    spin  = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++;
    if (dut.r_lfsr !== 16'hACE1) begin
      n_fail++;
      $display("FAIL reset_lfsr: got %h, required ace1", dut.r_lfsr);
    end
    @(negedge Clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      n_checks++;
      if (busy !== 1'b0 || spin_num !== 5'd0 || randnum !== 5'd0 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: busy=%b spin_num=%0d randnum=%0d result_valid=%b, required all 0",
                 i, busy, spin_num, randnum, result_valid);
      end
      n_checks++;
      if (dut.r_lfsr !== m_lfsr) begin
        n_fail++;
        $display("FAIL reset_lfsr_step cycle %0d: got %h, required %h", i, dut.r_lfsr, m_lfsr);
      end
    end
  endtask

  task automatic test_basic_spin;
    run_spin(0);
  endtask

  task automatic test_hold_and_respin;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clock); #1;
      n_checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0 || int'(randnum) !== exp_rand) begin
        n_fail++;
        $display("FAIL hold_no_respin cycle %0d: busy=%b result_valid=%b randnum=%0d, required 0 0 %0d",
                 i, busy, result_valid, randnum, exp_rand);
      end
    end
    @(negedge Clock);
    spin = 1'b0;
    @(posedge Clock);
    run_spin(0);
  endtask

  task automatic test_ignore_extra_edge;
    @(negedge Clock);
    spin = 1'b0;
    @(posedge Clock);
    run_spin(15);
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock); #1;
      n_checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL extra_edge_idle cycle %0d: busy=%b result_valid=%b, required 0 0", i, busy, result_valid);
      end
    end
  endtask

  task automatic test_midspin_reset;
    @(negedge Clock);
    spin = 1'b0;
    @(negedge Clock);
    spin = 1'b1;
    repeat (11) @(posedge Clock);
    #2;
    reset = 1'b1;
    spin  = 1'b0;
    #1;
    exp_num  = 0;
    exp_rand = 0;
    n_checks++;
    if (busy !== 1'b0 || spin_num !== 5'd0 || randnum !== 5'd0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b spin_num=%0d randnum=%0d result_valid=%b, required all 0",
               busy, spin_num, randnum, result_valid);
    end
    @(negedge Clock);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock); #1;
      n_checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset cycle %0d: busy=%b result_valid=%b, required 0 0", i, busy, result_valid);
      end
    end
    n_checks++;
    if (dut.r_lfsr !== m_lfsr) begin
      n_fail++;
      $display("FAIL after_reset_lfsr: got %h, required %h", dut.r_lfsr, m_lfsr);
    end
    run_spin(0);
  endtask

  task automatic test_random_spins;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock);
      spin = 1'b0;
      repeat ($urandom_range(1, 6)) @(posedge Clock);
      run_spin(0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_spin();
    test_hold_and_respin();
    test_ignore_extra_edge();
    test_midspin_reset();
    test_random_spins();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
